// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
//   Constants and types shared by the PWM link blocks (generator and capture).
//   PWM_CNT_W   : width of the duty code / generator counter
//   PWM_PERIOD  : nominal PWM period in clk cycles (2**PWM_CNT_W)
//   PWM_TIMEOUT : cycles without a rising edge before a line is declared stuck
//   pwm_state_e : capture FSM state (IDLE = no period reference yet)
// -----------------------------------------------------------------------------
package pwm_pkg;

  localparam int PWM_CNT_W   = 8;
  localparam int PWM_PERIOD  = 256;
  localparam int PWM_TIMEOUT = 512;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } pwm_state_e;

endpackage : pwm_pkg

// File: rtl/pwm_sync_edge.sv
// -----------------------------------------------------------------------------
// pwm_sync_edge
//   Two-flop synchroniser for an asynchronous input pin, followed by a one-cycle
//   delay stage used to detect edges on the synchronised signal.
// Ports:
//   clk      : system clock
//   rst      : synchronous reset, active-high (clears all three flops)
//   i_async  : asynchronous input pin
//   o_sync   : synchronised level (2 clk latency)
//   o_rise   : one-cycle pulse, o_sync went 0 -> 1
//   o_fall   : one-cycle pulse, o_sync went 1 -> 0
// -----------------------------------------------------------------------------
module pwm_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;  // first stage, may go metastable
  logic r_sync;  // second stage, safe to use
  logic r_dly;   // r_sync one cycle later, for edge detection

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_dly  <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_dly;
  assign o_fall = ~r_sync & r_dly;

endmodule : pwm_sync_edge

// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//   Samples an external PWM waveform and recovers the duty code (high cycles
//   per period) and the measured period, measured rise-to-rise. Reports
//   stuck-high / stuck-low lines after TIMEOUT cycles without a rising edge,
//   and flags periods that differ from the nominal PERIOD.
// Ports:
//   clk        : system clock, all logic on the rising edge
//   rst        : synchronous reset, active-high
//   pwm_in     : PWM waveform, asynchronous to clk
//   duty_out   : last recovered duty code, saturated to 2**CNT_W-1
//   duty_valid : one-cycle pulse when duty_out/period_out update
//   period_out : last measured period (0 after a stuck report)
//   period_err : last measured period != PERIOD, held until next update
//   stuck_hi   : line high for TIMEOUT cycles with no rising edge
//   stuck_lo   : line low for TIMEOUT cycles with no rising edge
// -----------------------------------------------------------------------------
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W   = PWM_CNT_W,
  parameter int PERIOD  = PWM_PERIOD,
  parameter int PER_W   = 16,
  parameter int TIMEOUT = PWM_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] duty_out,
  output logic             duty_valid,
  output logic [PER_W-1:0] period_out,
  output logic             period_err,
  output logic             stuck_hi,
  output logic             stuck_lo
);

  localparam logic [PER_W-1:0] CNT_ONE  = PER_W'(1);
  localparam logic [PER_W-1:0] CNT_MAX  = {PER_W{1'b1}};
  localparam logic [PER_W-1:0] DUTY_MAX = PER_W'((2 ** CNT_W) - 1);
  localparam logic [PER_W-1:0] NOM_PER  = PER_W'(PERIOD);
  localparam logic [PER_W-1:0] TO_CNT   = PER_W'(TIMEOUT);

  // ---------------------------------------------------------------------------
  // Input synchroniser / edge detector
  // ---------------------------------------------------------------------------
  logic w_pwm_s;
  logic w_rise;

  // Only rising edges delimit a period, so the falling-edge pulse is not used.
  pwm_sync_edge u_sync_edge (
    .clk     (clk),
    .rst     (rst),
    .i_async (pwm_in),
    .o_sync  (w_pwm_s),
    .o_rise  (w_rise),
    .o_fall  ()
  );

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  pwm_state_e       r_state;
  logic [PER_W-1:0] r_period_cnt;
  logic [PER_W-1:0] r_high_cnt;
  logic [CNT_W-1:0] r_duty;
  logic             r_duty_valid;
  logic [PER_W-1:0] r_period;
  logic             r_period_err;
  logic             r_stuck_hi;
  logic             r_stuck_lo;

  pwm_state_e       w_state;
  logic [PER_W-1:0] w_period_cnt;
  logic [PER_W-1:0] w_high_cnt;
  logic [CNT_W-1:0] w_duty;
  logic             w_duty_valid;
  logic [PER_W-1:0] w_period;
  logic             w_period_err;
  logic             w_stuck_hi;
  logic             w_stuck_lo;

  logic             w_timeout;
  logic [CNT_W-1:0] w_duty_sat;
  logic [PER_W-1:0] w_period_inc;
  logic [PER_W-1:0] w_high_inc;

  assign w_timeout    = (r_period_cnt == TO_CNT);
  assign w_duty_sat   = (r_high_cnt > DUTY_MAX) ? {CNT_W{1'b1}}
                                                : r_high_cnt[CNT_W-1:0];
  assign w_period_inc = (r_period_cnt == CNT_MAX) ? r_period_cnt
                                                  : r_period_cnt + CNT_ONE;
  assign w_high_inc   = (r_high_cnt == CNT_MAX) ? r_high_cnt
                                                : r_high_cnt + CNT_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
      r_duty       <= '0;
      r_duty_valid <= 1'b0;
      r_period     <= '0;
      r_period_err <= 1'b0;
      r_stuck_hi   <= 1'b0;
      r_stuck_lo   <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_period_cnt <= w_period_cnt;
      r_high_cnt   <= w_high_cnt;
      r_duty       <= w_duty;
      r_duty_valid <= w_duty_valid;
      r_period     <= w_period;
      r_period_err <= w_period_err;
      r_stuck_hi   <= w_stuck_hi;
      r_stuck_lo   <= w_stuck_lo;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that leaves
    // one unassigned would infer a latch.
    w_state      = r_state;
    w_period_cnt = w_period_inc;
    w_high_cnt   = w_pwm_s ? w_high_inc : r_high_cnt;
    w_duty       = r_duty;
    w_duty_valid = 1'b0;
    w_period     = r_period;
    w_period_err = r_period_err;
    w_stuck_hi   = r_stuck_hi;
    w_stuck_lo   = r_stuck_lo;

    // A rise takes priority over a timeout landing on the same cycle.
    if (w_rise) begin
      // The rise cycle itself is high and is the first cycle of the new period.
      w_period_cnt = CNT_ONE;
      w_high_cnt   = CNT_ONE;
      w_stuck_hi   = 1'b0;
      w_stuck_lo   = 1'b0;
      w_state      = MEASURE;
      case (r_state)
        MEASURE: begin
          w_duty       = w_duty_sat;
          w_period     = r_period_cnt;
          w_period_err = (r_period_cnt != NOM_PER);
          w_duty_valid = 1'b1;
        end
        default: ;  // IDLE: first period is partial, only arm the measurement
      endcase
    end else if (w_timeout) begin
      w_period_cnt = '0;
      w_high_cnt   = '0;
      w_state      = IDLE;
      // Report only once; a line that stays stuck just keeps re-arming.
      if (!r_stuck_hi && !r_stuck_lo) begin
        w_stuck_hi   = w_pwm_s;
        w_stuck_lo   = ~w_pwm_s;
        w_duty       = w_pwm_s ? {CNT_W{1'b1}} : '0;
        w_period     = '0;
        w_period_err = 1'b1;
        w_duty_valid = 1'b1;
      end
    end
  end

  assign duty_out   = r_duty;
  assign duty_valid = r_duty_valid;
  assign period_out = r_period;
  assign period_err = r_period_err;
  assign stuck_hi   = r_stuck_hi;
  assign stuck_lo   = r_stuck_lo;

endmodule : pwm_capture

// File: tb/tb_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_pwm_capture
//   Self-checking bench for pwm_capture. A monitor records every duty_valid
//   pulse; directed tables, hand-written corner sequences and a randomized
//   stream are compared against expectations computed from the waveform
//   parameters the bench itself generated.
// -----------------------------------------------------------------------------
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        pwm_in;
  logic [7:0]  duty_out;
  logic        duty_valid;
  logic [15:0] period_out;
  logic        period_err;
  logic        stuck_hi;
  logic        stuck_lo;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  pwm_capture dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .duty_out   (duty_out),
    .duty_valid (duty_valid),
    .period_out (period_out),
    .period_err (period_err),
    .stuck_hi   (stuck_hi),
    .stuck_lo   (stuck_lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed update events
  typedef struct {
    int duty;
    int per;
    int err;
    int shi;
    int slo;
    int t;
  } ev_t;

  ev_t obs[$];

  always @(negedge clk) begin
    if (!rst && duty_valid)
      obs.push_back('{int'(duty_out), int'(period_out), int'(period_err),
                      int'(stuck_hi), int'(stuck_lo), cyc});
  end

  // Expected update events for the random stream
  typedef struct {
    int duty;
    int per;
    int err;
  } exp_t;

  exp_t exp_q[$];

  // Directed table: waveform shape and the update it must produce
  typedef struct {
    int per;
    int hi;
    int n;
    int exp_duty;
    int exp_per;
    int exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    pwm_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    obs.delete();
  endtask

  // n generator-style periods: hi cycles high, then per-hi cycles low
  task automatic pwm_periods(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < per; j++) begin
        pwm_in = (j < hi);
        tick();
      end
    end
  endtask

  // One more rising edge to close the last period, long enough to propagate
  task automatic final_rise();
    pwm_in = 1'b1;
    repeat (5) tick();
    pwm_in = 1'b0;
    tick();
  endtask

  initial begin
    int c0;
    int t_rise;
    int per;
    int hi;
    int cnt;

    vecs[0] = '{256, 100, 3, 100, 256, 0};
    vecs[1] = '{200,  50, 3,  50, 200, 1};
    vecs[2] = '{256, 255, 3, 255, 256, 0};
    vecs[3] = '{256,   1, 3,   1, 256, 0};
    vecs[4] = '{300, 290, 3, 255, 300, 1};  // high count saturates to 255
    vecs[5] = '{100,  99, 3,  99, 100, 1};

    // ---- Reset state, then line held low ---------------------------------
    do_reset();
    check("rst_duty_out",   int'(duty_out),   0);
    check("rst_duty_valid", int'(duty_valid), 0);
    check("rst_period_out", int'(period_out), 0);
    check("rst_period_err", int'(period_err), 0);
    check("rst_stuck_hi",   int'(stuck_hi),   0);
    check("rst_stuck_lo",   int'(stuck_lo),   0);
    c0 = cyc;
    pwm_in = 1'b0;
    repeat (600) tick();
    check("lo_pulses", obs.size(), 1);
    if (obs.size() == 1) begin
      check("lo_time_ok", int'(obs[0].t >= c0 + 505 && obs[0].t <= c0 + 520), 1);
      check("lo_stuck_lo", obs[0].slo, 1);
      check("lo_stuck_hi", obs[0].shi, 0);
      check("lo_duty",     obs[0].duty, 0);
      check("lo_period",   obs[0].per, 0);
      check("lo_err",      obs[0].err, 1);
    end
    check("lo_stuck_lo_level", int'(stuck_lo), 1);

    // ---- Nominal 256/100 stream with latency and spacing -----------------
    do_reset();
    pwm_periods(256, 100, 1);
    check("nom_no_first_pulse", obs.size(), 0);
    t_rise = cyc;
    pwm_periods(256, 100, 3);
    final_rise();
    check("nom_pulses", obs.size(), 4);
    if (obs.size() == 4) begin
      check("nom_latency", obs[0].t, t_rise + 3);
      for (int i = 0; i < 4; i++) begin
        check("nom_duty",   obs[i].duty, 100);
        check("nom_period", obs[i].per, 256);
        check("nom_err",    obs[i].err, 0);
        if (i > 0) check("nom_spacing", obs[i].t - obs[i-1].t, 256);
      end
    end

    // ---- Table-driven shapes ---------------------------------------------
    for (int v = 0; v < 6; v++) begin
      do_reset();
      pwm_periods(vecs[v].per, vecs[v].hi, vecs[v].n);
      final_rise();
      check("tbl_pulses", obs.size(), vecs[v].n);
      foreach (obs[i]) begin
        check("tbl_duty",   obs[i].duty, vecs[v].exp_duty);
        check("tbl_period", obs[i].per,  vecs[v].exp_per);
        check("tbl_err",    obs[i].err,  vecs[v].exp_err);
        check("tbl_stuck",  obs[i].shi | obs[i].slo, 0);
      end
    end

    // ---- Generator code sweep --------------------------------------------
    for (int code = 0; code <= 255; code += 5) begin
      do_reset();
      pwm_periods(256, code, 3);
      if (code == 0) begin
        check("sweep0_pulses", obs.size(), 1);
        if (obs.size() == 1) begin
          check("sweep0_stuck_lo", obs[0].slo, 1);
          check("sweep0_duty",     obs[0].duty, 0);
        end
      end else begin
        final_rise();
        check("sweep_pulses", obs.size(), 3);
        foreach (obs[i]) begin
          check("sweep_duty", obs[i].duty, code);
          check("sweep_err",  obs[i].err, 0);
        end
      end
    end

    // ---- Off-nominal period, then return to nominal -----------------------
    do_reset();
    pwm_periods(200, 50, 2);
    pwm_periods(256, 100, 2);
    final_rise();
    check("ret_pulses", obs.size(), 4);
    if (obs.size() == 4) begin
      check("ret_off_duty",   obs[1].duty, 50);
      check("ret_off_period", obs[1].per, 200);
      check("ret_off_err",    obs[1].err, 1);
      check("ret_nom_err",    obs[2].err, 0);
      check("ret_nom_period", obs[2].per, 256);
      check("ret_nom_duty",   obs[3].duty, 100);
    end

    // ---- Stuck high after valid periods -----------------------------------
    do_reset();
    pwm_periods(256, 100, 2);
    pwm_in = 1'b1;
    repeat (600) tick();
    check("hi_pulses", obs.size(), 3);
    if (obs.size() == 3) begin
      check("hi_prev_duty", obs[1].duty, 100);
      check("hi_stuck_hi",  obs[2].shi, 1);
      check("hi_stuck_lo",  obs[2].slo, 0);
      check("hi_duty",      obs[2].duty, 255);
      check("hi_period",    obs[2].per, 0);
      check("hi_err",       obs[2].err, 1);
    end
    check("hi_level", int'(stuck_hi), 1);
    pwm_in = 1'b0;
    repeat (10) tick();
    pwm_in = 1'b1;
    repeat (4) tick();
    check("hi_cleared",    int'(stuck_hi), 0);
    check("hi_rise_quiet", obs.size(), 3);
    repeat (96) tick();
    pwm_in = 1'b0;
    repeat (156) tick();
    pwm_periods(256, 100, 1);
    final_rise();
    check("hi_after_pulses", obs.size(), 5);
    if (obs.size() == 5) begin
      check("hi_after_duty",   obs[3].duty, 100);
      check("hi_after_period", obs[3].per, 256);
      check("hi_after_stuck",  obs[3].shi, 0);
      check("hi_after_err",    obs[4].err, 0);
    end

    // ---- Reset in the middle of a period ----------------------------------
    do_reset();
    pwm_periods(256, 100, 1);
    for (int j = 0; j < 130; j++) begin
      pwm_in = (j < 100);
      tick();
    end
    check("mid_pre_pulses", obs.size(), 1);
    rst = 1'b1;
    tick();
    check("mid_duty_out",   int'(duty_out),   0);
    check("mid_duty_valid", int'(duty_valid), 0);
    check("mid_period_out", int'(period_out), 0);
    check("mid_period_err", int'(period_err), 0);
    check("mid_stuck",      int'(stuck_hi | stuck_lo), 0);
    rst = 1'b0;
    obs.delete();
    pwm_in = 1'b0;
    repeat (125) tick();
    pwm_periods(256, 100, 2);
    final_rise();
    check("mid_post_pulses", obs.size(), 2);
    if (obs.size() == 2) begin
      check("mid_post_duty",   obs[0].duty, 100);
      check("mid_post_period", obs[0].per, 256);
    end

    // ---- Randomized stream against the reference model --------------------
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      per = $urandom_range(400, 2);
      if ($urandom_range(4, 0) == 0) per = 256;
      hi = $urandom_range(per - 1, 1);
      // Each complete rise-to-rise period yields one update
      exp_q.push_back('{(hi > 255) ? 255 : hi, per, int'(per != 256)});
      pwm_periods(per, hi, 1);
    end
    final_rise();
    check("rnd_pulses", obs.size(), exp_q.size());
    cnt = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < cnt; i++) begin
      check("rnd_duty",   obs[i].duty, exp_q[i].duty);
      check("rnd_period", obs[i].per,  exp_q[i].per);
      check("rnd_err",    obs[i].err,  exp_q[i].err);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_pwm_capture
